i2c_poll_sched: RTL and testbench
=================================

# i2c_poll_sched

Round-robin poll scheduler that sequences the autofan I2C read engine, which has level-`GO`/`END_OK` handshaking. It polls up to `NUM_SLOT` sensor slaves and stores the last 16-bit reading per slot. Each slot has valid and error status. It detects hung transfers and recovers the engine through a reset output. The block sits between the fan-control logic, which reads the result registers, and the I2C read engine.

## Interface
- `NUM_SLOT`, 4: number of poll slots (1–8).
- `POLL_DIV`, 50000: `PT_CK` cycles from one round start to the next round start.
- `DONE_TO`, 4096: maximum cycles allowed in `WAIT_DONE`.
- `START_TO`, 8: maximum cycles allowed in `WAIT_START`.

Ports:
- `PT_CK`, in, 1: clock. Same clock as the I2C engine.
- `RESET`, in, 1: reset, asynchronous, active-high.
- `SLOT_EN`, in, `NUM_SLOT`: slot enable mask. Sampled in `SELECT`.
- `SLOT_ADDR`, in, `8*NUM_SLOT`: address byte for each slot, with the 7-bit address in bits [7:1]. Slot i uses bits [8i+7:8i].
- `SLOT_BYTES`, in, `8*NUM_SLOT`: passed through as the engine `BYTE_NUM`. The engine reads `BYTE_NUM+1` bytes.
- `FORCE`, in, 1: a pulse starts a round immediately when the block is in `WAIT_TICK`.
- `I2C_GO`, out, 1: engine `GO`. Idle high parks the engine.
- `I2C_RST`, out, 1: engine reset, active-high. The top level drives the engine `RESET_N` as `~I2C_RST`.
- `I2C_ADDR`, out, 8: engine `SLAVE_ADDRESS`.
- `I2C_BYTE_NUM`, out, 8: engine `BYTE_NUM`.
- `I2C_END_OK`, in, 1: engine `END_OK`.
- `I2C_ACK_OK`, in, 1: engine `ACK_OK`.
- `I2C_DATA`, in, 16: engine `DATA`.
- `RESULT`, out, `16*NUM_SLOT`: last good reading for each slot.
- `VALID`, out, `NUM_SLOT`: slot holds a reading from its most recent poll.
- `ERR`, out, `NUM_SLOT`: the most recent poll of the slot failed (NACK or timeout).
- `BUSY`, out, 1: high in every state except `WAIT_TICK`.
- `ROUND_DONE`, out, 1: one-cycle pulse at the end of each round.

## Operation
Reset values:
- `I2C_GO`=1, `I2C_RST`=1, `I2C_ADDR`=0, `I2C_BYTE_NUM`=0.
- `RESULT`=0, `VALID`=0, `ERR`=0, `ROUND_DONE`=0.
- State is `INIT`.

States:
- `INIT`: hold `I2C_RST`=1 for 2 cycles, then `I2C_RST`=0 with `I2C_GO`=1 for 4 cycles so the engine parks. Go to `WAIT_TICK` and load the poll counter.
- `WAIT_TICK`: the poll counter counts down. At 0, or on `FORCE`, go to `SELECT` with slot index 0 and reload the counter to `POLL_DIV-1`. The counter keeps running during the round.
- `SELECT`: search from the current index for the lowest enabled slot.
  - If one is found, latch its address and byte count onto `I2C_ADDR`/`I2C_BYTE_NUM` and go to `LAUNCH`.
  - If none remains, pulse `ROUND_DONE` and go to `WAIT_TICK`. If the counter already reached 0 during the round, the next round starts in the following cycle.
- `LAUNCH`: drive `I2C_GO`=0 for exactly one cycle, clear the sticky ACK flag, go to `WAIT_START`.
- `WAIT_START`: `I2C_GO`=1. A low on `I2C_END_OK` moves to `WAIT_DONE`. After `START_TO` cycles without it, raise a timeout.
- `WAIT_DONE`: set the sticky ACK flag whenever `I2C_ACK_OK`=1. The engine clears `ACK_OK` in the same cycle `END_OK` rises, so the flag must be sticky. A rise of `I2C_END_OK` moves to `STORE`. After `DONE_TO` cycles, raise a timeout.
- `STORE`, for slot i:
  - If the ACK flag is set: `RESULT[i]` = `I2C_DATA`, `VALID[i]`=1, `ERR[i]`=0.
  - If not: `RESULT[i]` is held, `VALID[i]`=0, `ERR[i]`=1.
  - Advance the index by 1 and go to `SELECT`.
- Timeout: `VALID[i]`=0, `ERR[i]`=1, then go to `RECOVER`.
- `RECOVER`: `I2C_RST`=1 for 2 cycles, then 4 park cycles as in `INIT`. Advance the index and go to `SELECT`.

Rules:
- A `SLOT_EN` change takes effect at the next `SELECT`. Slot configuration inputs are not sampled again mid-transfer.
- `I2C_ADDR`/`I2C_BYTE_NUM` stay stable from `SELECT` until the next `SELECT`.
- `RESET` asserted mid-transfer: everything returns to reset values at once. `I2C_RST`=1 aborts the engine.
- `FORCE` while `BUSY` is ignored and is not queued.
- The index counts 0..`NUM_SLOT-1` with no wrap. Reaching the end finishes the round.

## Timing
- `LAUNCH` at cycle T puts `I2C_GO`=0 in T and `I2C_GO`=1 from T+1. A parked engine drops `END_OK` at T+2.
- `STORE` is the cycle after the `END_OK` rise is sampled. `RESULT`/`VALID`/`ERR` update 1 cycle after `STORE`.
- Slot-to-slot overhead, measured from `END_OK` rising to the next `LAUNCH`, is 3 cycles: `STORE`, `SELECT`, `LAUNCH`.
- `ROUND_DONE` is asserted in the cycle after the final `SELECT`.
- Round period equals `POLL_DIV` cycles if the round fits inside it. Otherwise the next round starts the cycle after `ROUND_DONE`.
- `I2C_GO` is never low for more than 1 consecutive cycle. Otherwise the engine would free-run.

## Test plan
- Enabled slots 0 and 2 (0x98, 0x9A), `BYTE_NUM`=1, engine model returning 0x1234/0x5678 with ACK → `RESULT[0]`=0x1234, `RESULT[2]`=0x5678, `VALID`=0101, one `ROUND_DONE`, exactly two one-cycle `I2C_GO` lows.
- Slot 1 NACK (`I2C_ACK_OK` never high) → `ERR[1]`=1, `VALID[1]`=0, `RESULT[1]` unchanged from its previous value.
- Engine holds `END_OK` low forever → timeout after `DONE_TO` cycles, `I2C_RST` high for 2 cycles, `ERR` set, next slot polled normally.
- `SLOT_EN`=0 with `FORCE` → `ROUND_DONE` within 3 cycles, `I2C_GO` stays 1.
- `POLL_DIV`=100, with rounds taking 40 cycles → `ROUND_DONE` pulses spaced 100 cycles apart. With `FORCE` during `BUSY`, no extra round is started.
- `RESET` pulsed during `WAIT_DONE` → all outputs return to reset values immediately, and the block re-enters `INIT`.

Source files
------------

// File: rtl/i2c_poll_sched_if.sv
// i2c_poll_sched_if: handshake bundle between the poll scheduler and the
// autofan I2C read engine (level GO / END_OK protocol).
interface i2c_poll_sched_if;
    logic        I2C_GO;
    logic        I2C_RST;
    logic [7:0]  I2C_ADDR;
    logic [7:0]  I2C_BYTE_NUM;
    logic        I2C_END_OK;
    logic        I2C_ACK_OK;
    logic [15:0] I2C_DATA;

    modport master (
        output I2C_GO,
        output I2C_RST,
        output I2C_ADDR,
        output I2C_BYTE_NUM,
        input  I2C_END_OK,
        input  I2C_ACK_OK,
        input  I2C_DATA
    );

    modport slave (
        input  I2C_GO,
        input  I2C_RST,
        input  I2C_ADDR,
        input  I2C_BYTE_NUM,
        output I2C_END_OK,
        output I2C_ACK_OK,
        output I2C_DATA
    );
endinterface

// File: rtl/i2c_poll_sched.sv
// i2c_poll_sched: round-robin sensor poller driving the I2C read engine,
// keeping the last reading per slot plus valid/error status and hang recovery.
module i2c_poll_sched #(
    parameter int NUM_SLOT = 4,
    parameter int POLL_DIV = 50000,
    parameter int DONE_TO  = 4096,
    parameter int START_TO = 8
) (
    input  logic                    PT_CK,
    input  logic                    RESET,
    input  logic [NUM_SLOT-1:0]     SLOT_EN,
    input  logic [8*NUM_SLOT-1:0]   SLOT_ADDR,
    input  logic [8*NUM_SLOT-1:0]   SLOT_BYTES,
    input  logic                    FORCE,
    i2c_poll_sched_if.master        eng,
    output logic [16*NUM_SLOT-1:0]  RESULT,
    output logic [NUM_SLOT-1:0]     VALID,
    output logic [NUM_SLOT-1:0]     ERR,
    output logic                    BUSY,
    output logic                    ROUND_DONE
);

    localparam int IDX_W  = $clog2(NUM_SLOT + 1);
    localparam int TMAX_A = (DONE_TO > START_TO) ? DONE_TO : START_TO;
    localparam int TMAX   = (TMAX_A > 8) ? TMAX_A : 8;
    localparam int TMR_W  = $clog2(TMAX) + 1;
    localparam int CNT_W  = $clog2(POLL_DIV) + 1;
    localparam int RST_CY = 2;
    localparam int PARK_END = 5;

    typedef enum logic [2:0] {
        S_INIT,
        S_WAIT_TICK,
        S_SELECT,
        S_LAUNCH,
        S_WAIT_START,
        S_WAIT_DONE,
        S_STORE,
        S_RECOVER
    } state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [TMR_W-1:0]       tmr_q, tmr_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   ack_q, ack_d;
    logic [7:0]             addr_q, addr_d;
    logic [7:0]             bnum_q, bnum_d;
    logic [16*NUM_SLOT-1:0] result_q, result_d;
    logic [NUM_SLOT-1:0]    valid_q, valid_d;
    logic [NUM_SLOT-1:0]    err_q, err_d;
    logic                   rdone_q, rdone_d;

    logic                   hit;
    logic [IDX_W-1:0]       hit_idx;
    logic [7:0]             hit_addr;
    logic [7:0]             hit_bn;
    logic                   st_we;
    logic                   st_ok;

    // Lowest enabled slot at or above the current index; iterate downward
    // so the lowest match is the last one written.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        hit_addr = '0;
        hit_bn   = '0;
        for (int i = NUM_SLOT - 1; i >= 0; i--) begin
            if (SLOT_EN[i] && (IDX_W'(i) >= idx_q)) begin
                hit      = 1'b1;
                hit_idx  = IDX_W'(i);
                hit_addr = SLOT_ADDR[8*i +: 8];
                hit_bn   = SLOT_BYTES[8*i +: 8];
            end
        end
    end

    always_ff @(posedge PT_CK or posedge RESET) begin
        if (RESET) begin
            state_q  <= S_INIT;
            idx_q    <= '0;
            tmr_q    <= '0;
            cnt_q    <= '0;
            ack_q    <= 1'b0;
            addr_q   <= '0;
            bnum_q   <= '0;
            result_q <= '0;
            valid_q  <= '0;
            err_q    <= '0;
            rdone_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            tmr_q    <= tmr_d;
            cnt_q    <= cnt_d;
            ack_q    <= ack_d;
            addr_q   <= addr_d;
            bnum_q   <= bnum_d;
            result_q <= result_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            rdone_q  <= rdone_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        tmr_d    = tmr_q + TMR_W'(1);
        cnt_d    = cnt_q;
        ack_d    = ack_q;
        addr_d   = addr_q;
        bnum_d   = bnum_q;
        result_d = result_q;
        valid_d  = valid_q;
        err_d    = err_q;
        rdone_d  = 1'b0;
        st_we    = 1'b0;
        st_ok    = 1'b0;

        // Poll counter free-runs and parks at zero until a round can start.
        if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end

        unique case (state_q)
            S_INIT: begin
                if (tmr_q == TMR_W'(PARK_END)) begin
                    state_d = S_WAIT_TICK;
                    cnt_d   = CNT_W'(POLL_DIV - 1);
                end
            end
            S_WAIT_TICK: begin
                if ((cnt_q == '0) || FORCE) begin
                    state_d = S_SELECT;
                    idx_d   = '0;
                    cnt_d   = CNT_W'(POLL_DIV - 1);
                end
            end
            S_SELECT: begin
                if (hit) begin
                    idx_d   = hit_idx;
                    addr_d  = hit_addr;
                    bnum_d  = hit_bn;
                    state_d = S_LAUNCH;
                end else begin
                    rdone_d = 1'b1;
                    state_d = S_WAIT_TICK;
                end
            end
            S_LAUNCH: begin
                ack_d   = 1'b0;
                state_d = S_WAIT_START;
            end
            S_WAIT_START: begin
                if (!eng.I2C_END_OK) begin
                    state_d = S_WAIT_DONE;
                end else if (tmr_q == TMR_W'(START_TO - 1)) begin
                    st_we   = 1'b1;
                    state_d = S_RECOVER;
                end
            end
            S_WAIT_DONE: begin
                // Engine drops ACK_OK as END_OK rises, so keep it sticky.
                if (eng.I2C_ACK_OK) begin
                    ack_d = 1'b1;
                end
                if (eng.I2C_END_OK) begin
                    state_d = S_STORE;
                end else if (tmr_q == TMR_W'(DONE_TO - 1)) begin
                    st_we   = 1'b1;
                    state_d = S_RECOVER;
                end
            end
            S_STORE: begin
                st_we   = 1'b1;
                st_ok   = ack_q;
                idx_d   = idx_q + IDX_W'(1);
                state_d = S_SELECT;
            end
            S_RECOVER: begin
                if (tmr_q == TMR_W'(PARK_END)) begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = S_SELECT;
                end
            end
            default: begin
                state_d = S_INIT;
            end
        endcase

        if (state_d != state_q) begin
            tmr_d = '0;
        end

        for (int k = 0; k < NUM_SLOT; k++) begin
            if (st_we && (idx_q == IDX_W'(k))) begin
                valid_d[k] = st_ok;
                err_d[k]   = ~st_ok;
                if (st_ok) begin
                    result_d[16*k +: 16] = eng.I2C_DATA;
                end
            end
        end
    end

    assign eng.I2C_GO       = (state_q != S_LAUNCH);
    assign eng.I2C_RST      = ((state_q == S_INIT) || (state_q == S_RECOVER))
                              && (tmr_q < TMR_W'(RST_CY));
    assign eng.I2C_ADDR     = addr_q;
    assign eng.I2C_BYTE_NUM = bnum_q;

    assign RESULT     = result_q;
    assign VALID      = valid_q;
    assign ERR        = err_q;
    assign BUSY       = (state_q != S_WAIT_TICK);
    assign ROUND_DONE = rdone_q;

endmodule

// File: tb/tb_i2c_poll_sched.sv
// tb_i2c_poll_sched: directed bench with a behavioural I2C engine model
// and a scoreboard of per-slot results checked at each ROUND_DONE.
module tb_i2c_poll_sched;
    localparam int NS      = 4;
    localparam int PD      = 100;
    localparam int DTO     = 40;
    localparam int STO     = 8;
    localparam int ENG_LEN = 10;

    typedef struct {
        int          slot;
        logic        v;
        logic        e;
        logic [15:0] r;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [NS-1:0]     slot_en;
    logic [8*NS-1:0]   slot_addr;
    logic [8*NS-1:0]   slot_bytes;
    logic              frc;
    logic [16*NS-1:0]  result;
    logic [NS-1:0]     valid;
    logic [NS-1:0]     err;
    logic              busy;
    logic              rdone;

    i2c_poll_sched_if bus ();

    i2c_poll_sched #(
        .NUM_SLOT(NS),
        .POLL_DIV(PD),
        .DONE_TO (DTO),
        .START_TO(STO)
    ) dut (
        .PT_CK     (clk),
        .RESET     (rst),
        .SLOT_EN   (slot_en),
        .SLOT_ADDR (slot_addr),
        .SLOT_BYTES(slot_bytes),
        .FORCE     (frc),
        .eng       (bus),
        .RESULT    (result),
        .VALID     (valid),
        .ERR       (err),
        .BUSY      (busy),
        .ROUND_DONE(rdone)
    );

    always #5 clk = ~clk;

    int   n_chk  = 0;
    int   n_fail = 0;
    exp_t sbq[$];

    // Engine model: parked with END_OK high, drops it two cycles after a
    // GO low, optionally NACKs or hangs for one chosen address.
    logic       eng_busy;
    int         eng_cnt;
    logic [7:0] eng_addr;
    logic [7:0] nack_addr = 8'h00;
    logic [7:0] hang_addr = 8'h00;

    function automatic logic [15:0] data_for(input logic [7:0] a);
        case (a)
            8'h98:   return 16'h1234;
            8'h9A:   return 16'h5678;
            8'h9C:   return 16'h9ABC;
            8'h9E:   return 16'hDEF0;
            default: return 16'h0000;
        endcase
    endfunction

    always @(posedge clk) begin
        if (bus.I2C_RST) begin
            eng_busy       <= 1'b0;
            eng_cnt        <= 0;
            eng_addr       <= 8'h00;
            bus.I2C_END_OK <= 1'b1;
            bus.I2C_ACK_OK <= 1'b0;
            bus.I2C_DATA   <= 16'h0000;
        end else if (!eng_busy) begin
            if (!bus.I2C_GO) begin
                eng_busy <= 1'b1;
                eng_cnt  <= 0;
                eng_addr <= bus.I2C_ADDR;
            end
        end else begin
            eng_cnt <= eng_cnt + 1;
            if (eng_cnt == 0) bus.I2C_END_OK <= 1'b0;
            if (eng_cnt == 3 && eng_addr != nack_addr) bus.I2C_ACK_OK <= 1'b1;
            if (eng_cnt == ENG_LEN && eng_addr != hang_addr) begin
                bus.I2C_END_OK <= 1'b1;
                bus.I2C_ACK_OK <= 1'b0;
                bus.I2C_DATA   <= data_for(eng_addr);
                eng_busy       <= 1'b0;
            end
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int go_lows = 0;
    int go_run  = 0;
    int go_max  = 0;
    int rd_cnt  = 0;
    always @(negedge clk) begin
        if (!bus.I2C_GO) begin
            go_lows = go_lows + 1;
            go_run  = go_run + 1;
            if (go_run > go_max) go_max = go_run;
        end else begin
            go_run = 0;
        end
        if (rdone) rd_cnt = rd_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input int s, input logic v, input logic e,
                        input logic [15:0] r);
        exp_t x;
        x.slot = s;
        x.v    = v;
        x.e    = e;
        x.r    = r;
        sbq.push_back(x);
    endtask

    task automatic check_sb();
        exp_t x;
        while (sbq.size() > 0) begin
            x = sbq.pop_front();
            chk($sformatf("result%0d", x.slot), 64'(result[16*x.slot +: 16]), 64'(x.r));
            chk($sformatf("valid%0d", x.slot), 64'(valid[x.slot]), 64'(x.v));
            chk($sformatf("err%0d", x.slot), 64'(err[x.slot]), 64'(x.e));
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("idle", 64'(busy), 64'd0);
    endtask

    task automatic force_round();
        wait_idle();
        frc = 1'b1;
        @(negedge clk);
        frc = 1'b0;
    endtask

    task automatic wait_rd(input int lim, input string tag);
        int n = 0;
        @(negedge clk);
        while (!rdone && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 64'(rdone), 64'd1);
    endtask

    task automatic wait_end_low(input string tag);
        int n = 0;
        while (bus.I2C_END_OK && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 64'(bus.I2C_END_OK), 64'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_go"},    64'(bus.I2C_GO), 64'd1);
        chk({tag, "_rst"},   64'(bus.I2C_RST), 64'd1);
        chk({tag, "_addr"},  64'(bus.I2C_ADDR), 64'd0);
        chk({tag, "_bnum"},  64'(bus.I2C_BYTE_NUM), 64'd0);
        chk({tag, "_res"},   64'(result), 64'd0);
        chk({tag, "_valid"}, 64'(valid), 64'd0);
        chk({tag, "_err"},   64'(err), 64'd0);
        chk({tag, "_rd"},    64'(rdone), 64'd0);
        chk({tag, "_busy"},  64'(busy), 64'd1);
    endtask

    task automatic check_init_seq(input string tag);
        tick(1);
        chk({tag, "_rst_hi"}, 64'(bus.I2C_RST), 64'd1);
        tick(1);
        chk({tag, "_rst_lo"}, 64'(bus.I2C_RST), 64'd0);
        chk({tag, "_park_go"}, 64'(bus.I2C_GO), 64'd1);
        tick(3);
        chk({tag, "_park_busy"}, 64'(busy), 64'd1);
        tick(1);
        chk({tag, "_tick_idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int g0, r0, n, m, t1, t2, t3;
        rst        = 1'b1;
        frc        = 1'b0;
        slot_en    = '0;
        slot_addr  = {8'h9E, 8'h9A, 8'h9C, 8'h98};
        slot_bytes = {4{8'h01}};

        tick(2);
        check_reset_vals("reset");
        rst = 1'b0;
        check_init_seq("init");

        // Two-slot round with ACK
        g0 = go_lows;
        r0 = rd_cnt;
        slot_en = 4'b0101;
        push(0, 1'b1, 1'b0, 16'h1234);
        push(2, 1'b1, 1'b0, 16'h5678);
        force_round();
        wait_rd(200, "rd_round1");
        check_sb();
        chk("valid_round1", 64'(valid), 64'b0101);
        chk("err_round1", 64'(err), 64'b0000);
        chk("addr_hold", 64'(bus.I2C_ADDR), 64'h9A);
        chk("bnum_hold", 64'(bus.I2C_BYTE_NUM), 64'h01);
        tick(1);
        chk("rd_one_cycle", 64'(rdone), 64'd0);
        chk("rd_count1", 64'(rd_cnt - r0), 64'd1);
        chk("go_lows1", 64'(go_lows - g0), 64'd2);

        // Slot 1 good reading, then NACK keeps its old result
        slot_en = 4'b0111;
        push(1, 1'b1, 1'b0, 16'h9ABC);
        force_round();
        wait_rd(200, "rd_slot1_ok");
        check_sb();
        chk("valid_slot1_ok", 64'(valid), 64'b0111);

        nack_addr = 8'h9C;
        slot_en   = 4'b0010;
        push(1, 1'b0, 1'b1, 16'h9ABC);
        force_round();
        wait_rd(200, "rd_nack");
        check_sb();
        chk("valid_nack", 64'(valid), 64'b0101);
        chk("err_nack", 64'(err), 64'b0010);
        nack_addr = 8'h00;

        // Hung transfer on slot 1, slot 2 still serviced
        hang_addr = 8'h9C;
        slot_en   = 4'b0110;
        push(1, 1'b0, 1'b1, 16'h9ABC);
        push(2, 1'b1, 1'b0, 16'h5678);
        force_round();
        wait_end_low("hang_start");
        n = 0;
        while (!bus.I2C_RST && n < DTO + 20) begin
            @(negedge clk);
            n++;
        end
        chk("hang_timeout_cycles", 64'(n), 64'(DTO + 1));
        chk("hang_err_set", 64'(err[1]), 64'd1);
        m = 0;
        while (bus.I2C_RST && m < 10) begin
            m++;
            @(negedge clk);
        end
        chk("recover_rst_len", 64'(m), 64'd2);
        wait_rd(200, "rd_hang");
        check_sb();
        hang_addr = 8'h00;
        chk("go_max_run", 64'(go_max), 64'd1);

        // Empty mask: round finishes immediately without touching GO
        slot_en = 4'b0000;
        g0 = go_lows;
        wait_idle();
        frc = 1'b1;
        @(negedge clk);
        frc = 1'b0;
        n = 1;
        while (!rdone && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("empty_rd_within3", 64'(n <= 3), 64'd1);
        tick(2);
        chk("empty_go_lows", 64'(go_lows - g0), 64'd0);

        // Round period with FORCE ignored while busy
        slot_en = 4'b0101;
        wait_rd(250, "rd_period_a");
        t1 = cyc;
        n = 0;
        while (!busy && n < 150) begin
            @(negedge clk);
            n++;
        end
        chk("period_busy_seen", 64'(busy), 64'd1);
        frc = 1'b1;
        tick(3);
        frc = 1'b0;
        wait_rd(250, "rd_period_b");
        t2 = cyc;
        wait_rd(250, "rd_period_c");
        t3 = cyc;
        chk("period_ab", 64'(t2 - t1), 64'(PD));
        chk("period_bc", 64'(t3 - t2), 64'(PD));

        // Reset in the middle of WAIT_DONE
        slot_en = 4'b0001;
        force_round();
        wait_end_low("midrst_start");
        tick(2);
        chk("midrst_busy_before", 64'(busy), 64'd1);
        chk("midrst_addr_before", 64'(bus.I2C_ADDR), 64'h98);
        rst = 1'b1;
        #1;
        check_reset_vals("midrst");
        @(negedge clk);
        rst = 1'b0;
        check_init_seq("reinit");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
